// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arb_pkg                                                   |
// | Purpose  : Shared constants for the two-port datamemory arbiter: FSM     |
// |            state encodings and requester port identifiers.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  // FSM state encoding (IDLE -> ACCESS -> RESP -> IDLE)
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  // Requester identifiers: port 0 = L2 miss path, port 1 = I-side refill
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_pick2                                                      |
// | Purpose  : Combinational two-way round-robin pick. A lone requester wins;|
// |            on a conflict the port that did not win last time is chosen.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pick a winner from the current cycle's valids only
  always_comb begin
    gnt_valid = v0 | v1;
    if (v0 && v1) begin
      gnt_id = ~last_grant;
    end else if (v1) begin
      gnt_id = PORT1;
    end else begin
      gnt_id = PORT0;
    end
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Purpose  : Shares one non-pipelined datamemory port between the L2 miss  |
// |            path (port 0) and the I-side refill path (port 1) with a      |
// |            round-robin grant and a fixed MEM_LAT access latency.         |
// | Options  : MEM_ARB_PERF_EN adds saturating grant/conflict counters.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active low
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_id,
  output logic              mem_w,
  output logic              mem_r,
  input  logic [DATA_W-1:0] mem_od
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic gnt_valid;
  logic gnt_id;
  logic accept;
  logic in_access;
  logic in_resp;

  rr_pick2 u_pick (
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign accept    = (state_q == IDLE) && gnt_valid;
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Next-state, request latching and latency countdown
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          we_d         = (gnt_id == PORT1) ? req1_we    : req0_we;
          addr_d       = (gnt_id == PORT1) ? req1_addr  : req0_addr;
          wdata_d      = (gnt_id == PORT1) ? req1_wdata : req0_wdata;
          cnt_d        = CNT_W'(MEM_LAT - 1);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rdata_d = we_q ? '0 : mem_od;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers; reset drops any in-flight transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT1;
      id_q         <= PORT0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Requester-facing handshakes; ready is masked while reset is held so
  // every output reads 0 without waiting for a clock
  always_comb begin
    req0_ready  = rst && accept && (gnt_id == PORT0);
    req1_ready  = rst && accept && (gnt_id == PORT1);
    req0_rvalid = in_resp && (id_q == PORT0);
    req1_rvalid = in_resp && (id_q == PORT1);
    req0_rdata  = req0_rvalid ? rdata_q : '0;
    req1_rdata  = req1_rvalid ? rdata_q : '0;
  end

  // Memory-side drive, only active during ACCESS
  always_comb begin
    mem_addr = in_access ? addr_q : '0;
    mem_w    = in_access && we_q;
    mem_r    = in_access && !we_q;
    mem_id   = (in_access && we_q) ? wdata_q : '0;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_grant0_q, perf_grant0_d;
  logic [31:0] perf_grant1_q, perf_grant1_d;
  logic [31:0] perf_conflict_q, perf_conflict_d;

  // Saturating grant and conflict counters
  always_comb begin
    perf_grant0_d   = perf_grant0_q;
    perf_grant1_d   = perf_grant1_q;
    perf_conflict_d = perf_conflict_q;
    if (accept && (gnt_id == PORT0) && (perf_grant0_q != '1)) begin
      perf_grant0_d = perf_grant0_q + 32'd1;
    end
    if (accept && (gnt_id == PORT1) && (perf_grant1_q != '1)) begin
      perf_grant1_d = perf_grant1_q + 32'd1;
    end
    if ((state_q == IDLE) && req0_valid && req1_valid && (perf_conflict_q != '1)) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_grant0_q   <= perf_grant0_d;
      perf_grant1_q   <= perf_grant1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_arbiter                                                |
// | Purpose  : Directed self-checking bench for mem_arbiter. Instance A uses |
// |            MEM_LAT=2, instance B uses MEM_LAT=1. Memory read data is     |
// |            modelled as addr ^ 32'hDEADBEAF.                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A signals
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] mem_addr, mem_id, mem_od;
  logic        mem_w, mem_r;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  // Instance B signals
  logic        b_req0_valid = 0;
  logic [31:0] b_req0_addr = 0;
  logic        b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
  logic [31:0] b_req0_rdata, b_req1_rdata;
  logic [31:0] b_mem_addr, b_mem_id, b_mem_od;
  logic        b_mem_w, b_mem_r;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] b_perf_grant0, b_perf_grant1, b_perf_conflict;
`endif

  assign mem_od   = mem_addr ^ 32'hDEADBEAF;
  assign b_mem_od = b_mem_addr ^ 32'hDEADBEAF;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_addr(mem_addr), .mem_id(mem_id), .mem_w(mem_w), .mem_r(mem_r), .mem_od(mem_od)
`ifdef MEM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_we(1'b0), .req0_addr(b_req0_addr), .req0_wdata(32'h0),
    .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid), .req0_rdata(b_req0_rdata),
    .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(32'h0), .req1_wdata(32'h0),
    .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid), .req1_rdata(b_req1_rdata),
    .mem_addr(b_mem_addr), .mem_id(b_mem_id), .mem_w(b_mem_w), .mem_r(b_mem_r), .mem_od(b_mem_od)
`ifdef MEM_ARB_PERF_EN
    , .perf_grant0(b_perf_grant0), .perf_grant1(b_perf_grant1), .perf_conflict(b_perf_conflict)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    total_cnt++;
    if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 4'b0000) begin
      $display("FAIL reset_handshakes: got %b want 0000", {req0_ready, req1_ready, req0_rvalid, req1_rvalid});
    end else pass_cnt++;
    total_cnt++;
    if ({mem_r, mem_w, mem_addr, mem_id} !== 66'h0) begin
      $display("FAIL reset_mem: r=%b w=%b addr=%h id=%h want all 0", mem_r, mem_w, mem_addr, mem_id);
    end else pass_cnt++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h40;
    #1;
    total_cnt++;
    if (req0_ready !== 1'b1 || mem_r !== 1'b0) begin
      $display("FAIL read_ready_T: ready=%b mem_r=%b want 1 0", req0_ready, mem_r);
    end else pass_cnt++;
    tick();
    req0_valid = 1'b0;
    #1;
    total_cnt++;
    if (mem_r !== 1'b1 || mem_w !== 1'b0 || mem_addr !== 32'h40 || req0_ready !== 1'b0) begin
      $display("FAIL read_T1: r=%b w=%b addr=%h ready=%b want 1 0 40 0", mem_r, mem_w, mem_addr, req0_ready);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_r !== 1'b1 || req0_rvalid !== 1'b0) begin
      $display("FAIL read_T2: r=%b rvalid=%b want 1 0", mem_r, req0_rvalid);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 32'hDEADBEEF || mem_r !== 1'b0 || req1_rvalid !== 1'b0) begin
      $display("FAIL read_T3: rvalid=%b rdata=%h mem_r=%b rvalid1=%b want 1 deadbeef 0 0",
               req0_rvalid, req0_rdata, mem_r, req1_rvalid);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (req0_rvalid !== 1'b0) begin
      $display("FAIL read_T4_pulse: rvalid=%b want 0", req0_rvalid);
    end else pass_cnt++;
  endtask

  task automatic test_arbitration();
    int port;
    int cyc;
    do_reset();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h100;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
      port = -1;
      cyc = 0;
      #1;
      while (port < 0 && cyc < 20) begin
        if (req0_ready && req1_ready) port = 2;
        else if (req0_ready) port = 0;
        else if (req1_ready) port = 1;
        else begin
          tick();
          cyc++;
        end
      end
      total_cnt++;
      if (port !== (g % 2)) begin
        $display("FAIL arb_grant%0d: port=%0d want %0d", g, port, g % 2);
      end else pass_cnt++;
      total_cnt++;
      if (cyc !== ((g == 0) ? 0 : 3)) begin
        $display("FAIL arb_spacing%0d: waited %0d cycles want %0d", g, cyc, (g == 0) ? 0 : 3);
      end else pass_cnt++;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
`ifdef MEM_ARB_PERF_EN
    #1;
    total_cnt++;
    if (perf_grant0 !== 32'd2 || perf_grant1 !== 32'd2 || perf_conflict !== 32'd4) begin
      $display("FAIL perf_counts: g0=%0d g1=%0d conf=%0d want 2 2 4", perf_grant0, perf_grant1, perf_conflict);
    end else pass_cnt++;
`endif
    repeat (4) tick();
  endtask

  task automatic test_write();
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h10; req1_wdata = 32'h12345678;
    #1;
    total_cnt++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      $display("FAIL write_ready: ready1=%b ready0=%b want 1 0", req1_ready, req0_ready);
    end else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      #1;
      total_cnt++;
      if (mem_w !== 1'b1 || mem_r !== 1'b0 || mem_id !== 32'h12345678 || mem_addr !== 32'h10) begin
        $display("FAIL write_T%0d: w=%b r=%b id=%h addr=%h want 1 0 12345678 10", i, mem_w, mem_r, mem_id, mem_addr);
      end else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 32'h0 || req0_rvalid !== 1'b0 || mem_w !== 1'b0) begin
      $display("FAIL write_resp: rvalid1=%b rdata1=%h rvalid0=%b mem_w=%b want 1 0 0 0",
               req1_rvalid, req1_rdata, req0_rvalid, mem_w);
    end else pass_cnt++;
    req1_we = 1'b0;
    tick();
  endtask

  task automatic test_lat1();
    b_req0_valid = 1'b1; b_req0_addr = 32'h44;
    #1;
    total_cnt++;
    if (b_req0_ready !== 1'b1) begin
      $display("FAIL lat1_ready: ready=%b want 1", b_req0_ready);
    end else pass_cnt++;
    tick();
    b_req0_valid = 1'b0;
    #1;
    total_cnt++;
    if (b_mem_r !== 1'b1 || b_req0_rvalid !== 1'b0) begin
      $display("FAIL lat1_T1: mem_r=%b rvalid=%b want 1 0", b_mem_r, b_req0_rvalid);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (b_req0_rvalid !== 1'b1 || b_req0_rdata !== 32'hDEADBEEB || b_mem_r !== 1'b0) begin
      $display("FAIL lat1_T2: rvalid=%b rdata=%h mem_r=%b want 1 deadbeeb 0", b_req0_rvalid, b_req0_rdata, b_mem_r);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_access();
    int seen;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h80;
    tick();
    req0_valid = 1'b0;
    #1;
    total_cnt++;
    if (mem_r !== 1'b1 || mem_addr !== 32'h80) begin
      $display("FAIL midrst_access: mem_r=%b addr=%h want 1 80", mem_r, mem_addr);
    end else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({mem_r, mem_w, mem_addr, req0_rvalid, req0_ready} !== 36'h0) begin
      $display("FAIL midrst_async: mem_r=%b addr=%h rvalid=%b want 0 0 0", mem_r, mem_addr, req0_rvalid);
    end else pass_cnt++;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req0_rvalid || req1_rvalid || mem_r) seen++;
    end
    total_cnt++;
    if (seen !== 0) begin
      $display("FAIL midrst_dropped: activity cycles=%0d want 0", seen);
    end else pass_cnt++;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
    #1;
    total_cnt++;
    if (req1_ready !== 1'b1) begin
      $display("FAIL midrst_regrant: ready1=%b want 1", req1_ready);
    end else pass_cnt++;
    tick();
    req1_valid = 1'b0;
    repeat (2) tick();
    total_cnt++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 32'hDEADBE8F) begin
      $display("FAIL midrst_resp: rvalid1=%b rdata1=%h want 1 deadbe8f", req1_rvalid, req1_rdata);
    end else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_write();
    test_lat1();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_arbiter
`default_nettype wire
